// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants, pointer-width helper and the
// occupancy-flag bundle. Used by both the single- and dual-clock FIFOs.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Binary pointer width: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH flop storage: one synchronous write port and one
// asynchronous read port. Storage is never reset.
module fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// standard or first-word-fall-through reads, flush and sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [ptr_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count_q;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] head;
    fifo_flags_t           flags;

    // Flags decode straight from the registered count: no extra latency.
    always_comb begin
        flags              = '0;
        flags.full         = (count_q == PW'(DEPTH));
        flags.empty        = (count_q == '0);
        flags.almost_full  = (count_q >= PW'(AF_LEVEL));
        flags.almost_empty = (count_q <= PW'(AE_LEVEL));
    end

    // A write into a full FIFO is only taken when a read frees a slot.
    always_comb begin
        rd_acc = rd && !flags.empty;
        wr_acc = wr && (!flags.full || rd_acc);
        mem_we = wr_acc && !flush && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + PW'(1);
                2'b01:   count_q <= count_q - PW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (wr && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign rd_data  = head;
            assign rd_valid = !flags.empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // rd_data holds its last value; rd_valid pulses once per read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= head;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode instance (AF=6, AE=2) and an FWFT
// instance with default thresholds, checked against an expected-data queue.
module tb_sync_fifo;

    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 2;

    logic clk = 1'b0;
    logic rst;

    logic       s_flush, s_wr, s_rd;
    logic [7:0] s_wr_data, s_rd_data;
    logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0] s_count;

    logic       f_flush, f_wr, f_rd;
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] f_count;

    logic [7:0] exp_q[$];
    logic [7:0] exp_d;
    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .DEPTH(DEPTH), .DATA_WIDTH(8), .AF_LEVEL(AF_LVL), .AE_LEVEL(AE_LVL), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst), .flush(s_flush), .wr(s_wr), .wr_data(s_wr_data),
        .rd(s_rd), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo #(
        .DEPTH(DEPTH), .DATA_WIDTH(8), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr(f_wr), .wr_data(f_wr_data),
        .rd(f_rd), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s_flush = 0; s_wr = 0; s_rd = 0; s_wr_data = '0;
        f_flush = 0; f_wr = 0; f_rd = 0; f_wr_data = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", s_count); end
        checks++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b want 1010", {s_empty, s_full, s_ae, s_af}); end
        checks++; if ({s_rd_valid, s_ovf, s_udf} !== 3'b000) begin errors++; $display("FAIL reset_sticky got %b want 000", {s_rd_valid, s_ovf, s_udf}); end
        checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", s_rd_data); end
        checks++; if ({f_empty, f_rd_valid, f_ae, f_af} !== 4'b1010) begin errors++; $display("FAIL reset_fwft got %b want 1010", {f_empty, f_rd_valid, f_ae, f_af}); end
    endtask

    task automatic test_fill_drain();
        apply_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            s_wr = 1; s_wr_data = 8'(i); exp_q.push_back(8'(i));
            tick();
        end
        checks++; if ({s_full, s_count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL fill_full got full=%b count=%0d want full=1 count=8", s_full, s_count); end
        s_wr_data = 8'h09;
        tick();
        s_wr = 0;
        checks++; if ({s_ovf, s_count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL fill_overflow got ovf=%b count=%0d want ovf=1 count=8", s_ovf, s_count); end
        s_rd = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            exp_d = exp_q.pop_front();
            checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, s_rd_valid, s_rd_data, exp_d); end
        end
        s_rd = 0;
        tick();
        checks++; if ({s_rd_valid, s_empty, s_udf} !== 3'b010) begin errors++; $display("FAIL drain_end got v/empty/udf=%b want 010", {s_rd_valid, s_empty, s_udf}); end
    endtask

    task automatic test_underflow();
        apply_reset();
        s_rd = 1;
        tick();
        s_rd = 0;
        checks++; if ({s_udf, s_rd_valid, s_count} !== {2'b10, 4'd0}) begin errors++; $display("FAIL underflow_set got udf=%b v=%b count=%0d want 1 0 0", s_udf, s_rd_valid, s_count); end
        s_flush = 1;
        tick();
        s_flush = 0;
        checks++; if (s_udf !== 1'b1) begin errors++; $display("FAIL underflow_after_flush got %b want 1", s_udf); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (s_udf !== 1'b0) begin errors++; $display("FAIL underflow_after_rst got %b want 0", s_udf); end
    endtask

    task automatic test_full_rw();
        apply_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            s_wr = 1; s_wr_data = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
            tick();
        end
        s_wr_data = 8'hAA; s_rd = 1; exp_q.push_back(8'hAA);
        tick();
        s_wr = 0;
        exp_d = exp_q.pop_front();
        checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL full_rw_data got v=%b d=%h want v=1 d=%h", s_rd_valid, s_rd_data, exp_d); end
        checks++; if ({s_count, s_full, s_ovf} !== {4'd8, 2'b10}) begin errors++; $display("FAIL full_rw_state got count=%0d full=%b ovf=%b want 8 1 0", s_count, s_full, s_ovf); end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            exp_d = exp_q.pop_front();
            checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL full_rw_drain[%0d] got v=%b d=%h want v=1 d=%h", i, s_rd_valid, s_rd_data, exp_d); end
        end
        s_rd = 0;
        tick();
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty got %b want 1", s_empty); end
    endtask

    task automatic test_thresholds();
        bit want_ae, want_af;
        apply_reset();
        for (int n = 1; n <= DEPTH; n++) begin
            s_wr = 1; s_wr_data = 8'(n);
            tick();
            want_ae = (n <= AE_LVL);
            want_af = (n >= AF_LVL);
            checks++; if ({s_ae, s_af} !== {want_ae, want_af}) begin errors++; $display("FAIL thresh_count%0d got ae=%b af=%b want ae=%b af=%b", n, s_ae, s_af, want_ae, want_af); end
        end
        s_wr = 0;
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            s_wr = 1; s_wr_data = 8'(8'hA0 + i); exp_q.push_back(8'(8'hA0 + i));
            tick();
        end
        s_wr = 0; s_rd = 1;
        tick();
        exp_d = exp_q.pop_front();
        checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL flush_pre_read got v=%b d=%h want v=1 d=%h", s_rd_valid, s_rd_data, exp_d); end
        s_rd = 0; s_flush = 1; s_wr = 1; s_wr_data = 8'hEE;
        tick();
        s_flush = 0; s_wr = 0;
        exp_q.delete();
        checks++; if ({s_count, s_empty, s_rd_valid, s_ovf, s_udf} !== {4'd0, 4'b1000}) begin errors++; $display("FAIL flush_state got count=%0d e/v/o/u=%b want 0 1000", s_count, {s_empty, s_rd_valid, s_ovf, s_udf}); end
        s_wr = 1; s_wr_data = 8'hB5; exp_q.push_back(8'hB5);
        tick();
        s_wr = 0; s_rd = 1;
        tick();
        s_rd = 0;
        exp_d = exp_q.pop_front();
        checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL flush_post_read got v=%b d=%h want v=1 d=%h", s_rd_valid, s_rd_data, exp_d); end
    endtask

    task automatic test_fwft();
        apply_reset();
        f_wr = 1; f_wr_data = 8'h5C;
        tick();
        f_wr = 0;
        checks++; if ({f_rd_valid, f_rd_data} !== {1'b1, 8'h5C}) begin errors++; $display("FAIL fwft_head got v=%b d=%h want v=1 d=5c", f_rd_valid, f_rd_data); end
        tick();
        checks++; if ({f_rd_valid, f_rd_data} !== {1'b1, 8'h5C}) begin errors++; $display("FAIL fwft_hold got v=%b d=%h want v=1 d=5c", f_rd_valid, f_rd_data); end
        f_rd = 1;
        tick();
        f_rd = 0;
        checks++; if ({f_empty, f_rd_valid, f_udf} !== 3'b100) begin errors++; $display("FAIL fwft_pop got e/v/u=%b want 100", {f_empty, f_rd_valid, f_udf}); end
        f_wr = 1; f_wr_data = 8'h31;
        tick();
        f_wr_data = 8'h32;
        tick();
        f_wr = 0; f_rd = 1;
        checks++; if (f_rd_data !== 8'h31) begin errors++; $display("FAIL fwft_first got %h want 31", f_rd_data); end
        tick();
        f_rd = 0;
        checks++; if ({f_rd_valid, f_rd_data, f_count} !== {1'b1, 8'h32, 4'd1}) begin errors++; $display("FAIL fwft_second got v=%b d=%h count=%0d want 1 32 1", f_rd_valid, f_rd_data, f_count); end
    endtask

    // Preload cycles push the pointers near the wrap, then random traffic
    // crosses it; finally occupancy is steered to 5 and reset hits mid-read.
    task automatic test_wrap_random();
        int  m_cnt;
        bit  w, r, racc, wacc;
        apply_reset();
        m_cnt = 0;
        for (int i = 0; i < 28 + 20 + 16; i++) begin
            if (i < 28) begin
                w = (i % 14) < 7;
                r = !w;
            end else if (i < 48) begin
                w = $urandom_range(0, 99) < 60;
                r = $urandom_range(0, 99) < 50;
            end else begin
                w = m_cnt < 5;
                r = m_cnt > 5;
            end
            s_wr = w; s_rd = r; s_wr_data = 8'($urandom_range(1, 255));
            racc = r && (m_cnt > 0);
            wacc = w && ((m_cnt < DEPTH) || racc);
            if (wacc) exp_q.push_back(s_wr_data);
            tick();
            if (racc) begin
                exp_d = exp_q.pop_front();
                checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL wrap_data[%0d] got v=%b d=%h want v=1 d=%h", i, s_rd_valid, s_rd_data, exp_d); end
            end else begin
                checks++; if (s_rd_valid !== 1'b0) begin errors++; $display("FAIL wrap_novalid[%0d] got %b want 0", i, s_rd_valid); end
            end
            m_cnt = m_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
            checks++; if (s_count !== 4'(m_cnt)) begin errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, s_count, m_cnt); end
        end
        s_wr = 0;
        s_rd = 1;
        tick();
        checks++; if ({s_rd_valid, s_count} !== {1'b1, 4'd4}) begin errors++; $display("FAIL wrap_inflight got v=%b count=%0d want 1 4", s_rd_valid, s_count); end
        rst = 1;
        tick();
        rst = 0; s_rd = 0;
        checks++; if ({s_count, s_empty, s_full, s_ae, s_af} !== {4'd0, 4'b1010}) begin errors++; $display("FAIL rst_mid_flags got count=%0d e/f/ae/af=%b want 0 1010", s_count, {s_empty, s_full, s_ae, s_af}); end
        checks++; if ({s_rd_data, s_rd_valid, s_ovf, s_udf} !== {8'h00, 3'b000}) begin errors++; $display("FAIL rst_mid_out got d=%h v/o/u=%b want 00 000", s_rd_data, {s_rd_valid, s_ovf, s_udf}); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_full_rw();
        test_thresholds();
        test_flush();
        test_fwft();
        test_wrap_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
